alu_core: RTL and testbench
===========================

ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 64 bits.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  high when alu_control/rs1/rs2 carry an operation to execute this cycle.
REQ-005 alu_control  input  4  operation select.
REQ-006 rs1  input  64  first operand.
REQ-007 rs2  input  64  second operand.
REQ-008 rd  output  64  registered result.
REQ-009 alu_zero  output  1  high when rd equals 64'h0.
REQ-010 out_valid  output  1  high for one cycle when rd/alu_zero hold a new result.

Function
REQ-011 The block SHALL have one clock domain (clk) and SHALL reset asynchronously on rst_n low.
REQ-012 Opcode map: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (rs1-rs2), 0011 XOR, 1100 NOR, 0100 SLL, 0101 SRL, 0111 SRA, 1000 SLT (signed), 1001 SLTU (unsigned).
REQ-013 Any unlisted opcode SHALL produce rd = 64'h0.
REQ-014 ADD/SUB SHALL be modulo 2^64; carry-out and overflow SHALL be discarded.
REQ-015 Shift amount SHALL be rs2[5:0]; SRA SHALL replicate rs1[63]; SLL/SRL SHALL fill zeros.
REQ-016 SLT/SLTU SHALL return 64'h1 if rs1 < rs2 (two's complement / unsigned), else 64'h0.
REQ-017 Latency SHALL be exactly one cycle: a result for operands sampled at edge N, with in_valid high, SHALL appear on rd at edge N.
REQ-018 When in_valid is high at a rising edge, out_valid SHALL be 1 after that edge; when low, out_valid SHALL be 0 and rd/alu_zero SHALL hold.
REQ-019 Back-to-back in_valid SHALL be accepted every cycle with no stall.
REQ-020 alu_zero SHALL be derived from the registered rd, always consistent with rd in the same cycle, independent of opcode.

Reset
REQ-021 While rst_n is low: rd = 64'h0, out_valid = 0, alu_zero = 1.
REQ-022 Reset assertion mid-operation SHALL discard the in-flight result immediately, without waiting for a clock edge.
REQ-023 After rst_n deasserts, the first operation SHALL be accepted at the first rising edge with in_valid high.

Verification
REQ-024 rs1=A5A5A5A5A5A5A5A5, rs2=5A5A5A5A5A5A5A5A, op 0000 -> rd=0000000000000000, alu_zero=1; op 0001 -> rd=FFFFFFFFFFFFFFFF, alu_zero=0.
REQ-025 Same operands, op 0010 -> rd=FFFFFFFFFFFFFFFF; op 0110 -> rd=4B4B4B4B4B4B4B4B, alu_zero=0.
REQ-026 rs1=rs2=FFFFFFFFFFFFFFFF, op 0010 -> rd=FFFFFFFFFFFFFFFE (carry dropped), alu_zero=0.
REQ-027 rs1=rs2=0, op 0110 -> rd=0, alu_zero=1, out_valid=1 one cycle after in_valid.
REQ-028 rs1=8000000000000000, rs2=4: SRA -> F800000000000000; SRL -> 0800000000000000; SLT with rs2=1 -> 1; SLTU with rs2=1 -> 0.
REQ-029 Apply rst_n low between clock edges during back-to-back operations -> rd=0, out_valid=0, alu_zero=1 without a clock edge; an opcode of 1111 -> rd=0.

Source files
------------

// File: rtl/alu_core_if.sv
// alu_core_if: operand/result bundle for the 64-bit single-cycle ALU.
//   master : drives in_valid, alu_control, rs1, rs2; receives rd, alu_zero, out_valid
//   slave  : the ALU side (receives operands, drives the registered result)
interface alu_core_if;
  logic        in_valid;
  logic [3:0]  alu_control;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [63:0] rd;
  logic        alu_zero;
  logic        out_valid;

  modport master (
    output in_valid, alu_control, rs1, rs2,
    input  rd, alu_zero, out_valid
  );

  modport slave (
    input  in_valid, alu_control, rs1, rs2,
    output rd, alu_zero, out_valid
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: 64-bit ALU with a registered result and one-cycle latency.
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - asynchronous active-low reset (rd=0, out_valid=0, alu_zero=1)
//   bus   - alu_core_if.slave: in_valid/alu_control/rs1/rs2 in, rd/alu_zero/out_valid out
module alu_core (
  input  logic       clk,
  input  logic       rst_n,
  alu_core_if.slave  bus
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpSlt  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1001;
  localparam logic [3:0] OpNor  = 4'b1100;

  logic [63:0] result;
  logic [5:0]  shamt;
  logic [63:0] rd_q, rd_d;
  logic        out_valid_q, out_valid_d;

  assign shamt = bus.rs2[5:0];

  always_comb begin
    result = '0;
    case (bus.alu_control)
      OpAnd:  result = bus.rs1 & bus.rs2;
      OpOr:   result = bus.rs1 | bus.rs2;
      OpAdd:  result = bus.rs1 + bus.rs2;   // carry-out dropped
      OpSub:  result = bus.rs1 - bus.rs2;   // borrow dropped
      OpXor:  result = bus.rs1 ^ bus.rs2;
      OpNor:  result = ~(bus.rs1 | bus.rs2);
      OpSll:  result = bus.rs1 << shamt;
      OpSrl:  result = bus.rs1 >> shamt;
      OpSra:  result = $unsigned($signed(bus.rs1) >>> shamt);
      OpSlt:  result = {63'd0, $signed(bus.rs1) < $signed(bus.rs2)};
      OpSltu: result = {63'd0, bus.rs1 < bus.rs2};
      default: result = '0;                 // unlisted opcodes yield zero
    endcase
  end

  // rd holds its value on idle cycles; out_valid pulses once per accepted op.
  always_comb begin
    rd_d        = rd_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      rd_d = result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.rd        = rd_q;
  assign bus.out_valid = out_valid_q;
  // Derived from the register so it always tracks rd, including during reset.
  assign bus.alu_zero  = (rd_q == 64'd0);

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core. Expected results are queued when an
// operation is driven and popped when the DUT reports it.
module tb_alu_core;

  logic clk;
  logic rst_n;
  alu_core_if bus ();

  alu_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_rd = 64'd0;
  logic        mon_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Independent reference: subtraction via two's complement, signed compare via
  // sign-bit flip, arithmetic shift via explicit fill loop.
  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] r;
    logic [63:0] msb;
    int sh;
    sh  = int'(b[5:0]);
    msb = 64'h8000_0000_0000_0000;
    r   = 64'd0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a + ~b + 64'd1;
      4'b0011: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b0100: r = a << sh;
      4'b0101: r = a >> sh;
      4'b0111: begin
        r = a >> sh;
        for (int i = 0; i < 64; i++) if (a[63] && i >= 64 - sh) r[i] = 1'b1;
      end
      4'b1000: r = ((a ^ msb) < (b ^ msb)) ? 64'd1 : 64'd0;
      4'b1001: r = (a < b) ? 64'd1 : 64'd0;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.rs1         = a;
    bus.rs2         = b;
    exp_q.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  // Monitor: sample in_valid at the edge, check outputs 1 time unit later.
  always @(posedge clk) begin
    mon_v = bus.in_valid;
    #1;
    if (!rst_n) begin
      last_rd = 64'd0;
    end else begin
      check("out_valid", {63'd0, bus.out_valid}, {63'd0, mon_v});
      if (mon_v) begin
        if (exp_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else last_rd = exp_q.pop_front();
      end
      check("rd", bus.rd, last_rd);
      check("alu_zero", {63'd0, bus.alu_zero}, {63'd0, last_rd == 64'd0});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  localparam logic [63:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] X5 = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] F1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M8 = 64'h8000_0000_0000_0000;

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    logic [3:0]  ops [14];
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'hA, 4'hF, 4'hD};

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'h0;
    bus.rs1         = 64'd0;
    bus.rs2         = 64'd0;
    #2;
    check("reset_rd", bus.rd, 64'd0);
    check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset_alu_zero", {63'd0, bus.alu_zero}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    drive(4'b0000, A5, X5, 64'd0);
    drive(4'b0001, A5, X5, F1);
    drive(4'b0010, A5, X5, F1);
    drive(4'b0110, A5, X5, 64'h4B4B_4B4B_4B4B_4B4B);
    drive(4'b0010, F1, F1, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(1);
    drive(4'b0110, 64'd0, 64'd0, 64'd0);
    idle(2);
    drive(4'b0111, M8, 64'd4, 64'hF800_0000_0000_0000);
    drive(4'b0101, M8, 64'd4, 64'h0800_0000_0000_0000);
    drive(4'b1000, M8, 64'd1, 64'd1);
    drive(4'b1001, M8, 64'd1, 64'd0);
    drive(4'b0100, 64'h1, 64'h7F, M8);            // only rs2[5:0] counts
    drive(4'b1100, A5, 64'd0, X5);
    drive(4'b1111, A5, X5, 64'd0);
    drive(4'b0011, A5, X5, F1);
    idle(1);

    // Random mix, including unlisted opcodes and idle gaps.
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 13)];
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if (i % 5 == 0) a = M8 | a;
      drive(op, a, b, ref_alu(op, a, b));
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // Asynchronous reset mid-stream: no clock edge between assert and check.
    drive(4'b0001, A5, X5, F1);
    drive(4'b0001, A5, X5, F1);
    @(posedge clk);
    #3;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("async_rst_rd", bus.rd, 64'd0);
    check("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("async_rst_alu_zero", {63'd0, bus.alu_zero}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // First op after reset release is accepted immediately.
    drive(4'b0010, 64'd5, 64'd7, 64'd12);
    drive(4'b1111, F1, F1, 64'd0);
    idle(3);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
